// File: rtl/alu_arb_pkg.sv
// Shared types and widths for the two-port ALU arbiter.
package alu_arb_pkg;

  localparam int OP_W   = 4;   // requester select field width
  localparam int DATA_W = 8;   // operand width
  localparam int RES_W  = 16;  // ALU result width

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin picker. Purely combinational: a lone valid input
// wins outright, a tie goes to the input named by prio.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       prio,
  output logic       grant_valid,
  output logic       grant_idx
);

  // Pick the winner; on a tie the priority pointer decides.
  always_comb begin
    grant_valid = |valid;
    if (valid == 2'b11) begin
      grant_idx = prio;
    end else begin
      grant_idx = valid[1];
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two requesters. One operation is in flight at a
// time: accept in IDLE, pulse the ALU enable in ISSUE, count out the ALU
// latency, capture the result and hold it on the owner's response port.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int unsigned ALU_LAT = 2,     // 1..15
  parameter logic        EN_ACT  = 1'b0   // active level of alu_en
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [2*DATA_W-1:0] req_a,
  input  logic [2*DATA_W-1:0] req_b,
  input  logic [2*OP_W-1:0]   req_s,
  output logic [1:0]          rsp_valid,
  input  logic [1:0]          rsp_ready,
  output logic [RES_W-1:0]    rsp_y,
  output logic                rsp_carry,
  output logic                rsp_zero,
  output logic [DATA_W-1:0]   alu_a,
  output logic [DATA_W-1:0]   alu_b,
  output logic [7:0]          alu_s,
  output logic                alu_en,
  input  logic [RES_W-1:0]    alu_y,
  input  logic                alu_carry,
  input  logic                alu_zero
);

  // cnt is loaded on accept and counts down through ISSUE and WAIT; the
  // cycle in which it reads zero is the one where the ALU output is valid.
  localparam logic [3:0] LAT_M1 = 4'(ALU_LAT - 1);

  state_e              state_q, state_d;
  logic                prio_q, prio_d;
  logic                owner_q, owner_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [DATA_W-1:0]   alu_a_q, alu_a_d;
  logic [DATA_W-1:0]   alu_b_q, alu_b_d;
  logic [OP_W-1:0]     alu_s_q, alu_s_d;
  logic [RES_W-1:0]    rsp_y_q, rsp_y_d;
  logic                rsp_carry_q, rsp_carry_d;
  logic                rsp_zero_q, rsp_zero_d;

  logic                grant_valid;
  logic                grant_idx;

  rr_arb2 u_rr_arb2 (
    .valid       (req_valid),
    .prio        (prio_q),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  // Next-state, datapath loads and handshake outputs.
  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_s_d     = alu_s_q;
    rsp_y_d     = rsp_y_q;
    rsp_carry_d = rsp_carry_q;
    rsp_zero_d  = rsp_zero_q;
    req_ready   = 2'b00;
    rsp_valid   = 2'b00;
    alu_en      = ~EN_ACT;

    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          req_ready = grant_idx ? 2'b10 : 2'b01;
          owner_d   = grant_idx;
          alu_a_d   = grant_idx ? req_a[2*DATA_W-1:DATA_W] : req_a[DATA_W-1:0];
          alu_b_d   = grant_idx ? req_b[2*DATA_W-1:DATA_W] : req_b[DATA_W-1:0];
          alu_s_d   = grant_idx ? req_s[2*OP_W-1:OP_W] : req_s[OP_W-1:0];
          cnt_d     = LAT_M1;
          state_d   = ISSUE;
        end
      end
      ISSUE, WAIT: begin
        if (state_q == ISSUE) begin
          alu_en = EN_ACT;
        end
        if (cnt_q == 4'd0) begin
          rsp_y_d     = alu_y;
          rsp_carry_d = alu_carry;
          rsp_zero_d  = alu_zero;
          state_d     = RESP;
        end else begin
          cnt_d   = cnt_q - 4'd1;
          state_d = WAIT;
        end
      end
      RESP: begin
        rsp_valid = owner_q ? 2'b10 : 2'b01;
        if (rsp_ready[owner_q]) begin
          prio_d  = ~owner_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      prio_q      <= 1'b0;
      owner_q     <= 1'b0;
      cnt_q       <= 4'd0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_s_q     <= '0;
      rsp_y_q     <= '0;
      rsp_carry_q <= 1'b0;
      rsp_zero_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      prio_q      <= prio_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_s_q     <= alu_s_d;
      rsp_y_q     <= rsp_y_d;
      rsp_carry_q <= rsp_carry_d;
      rsp_zero_q  <= rsp_zero_d;
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_s     = {{(8 - OP_W){1'b0}}, alu_s_q};
  assign rsp_y     = rsp_y_q;
  assign rsp_carry = rsp_carry_q;
  assign rsp_zero  = rsp_zero_q;

endmodule
